mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Channel sequencer that sits directly upstream of a 4:1 single-bit mux. It drives the mux select lines, walks through the enabled channels, and dwells a programmable number of cycles on each one. It samples the mux output into a 4-bit frame and hands the completed frame downstream over a valid/ready handshake. It supports single-shot and continuous scanning, with sticky overrun detection.

Parameters:
DWELL, 4, cycles spent on each enabled channel (legal range 1..255); the sample is taken on the last dwell cycle.
CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W >= DWELL.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
continuous  input  1  1 = rescan immediately after each frame; sampled at frame completion
mask  input  4  channel enable, bit n = channel n; latched on an accepted start
mux_out  input  1  selected bit returned from the downstream 4:1 mux
sel  output  2  select lines driven to the mux
frame  output  4  completed frame; disabled channels read 0
frame_valid  output  1  frame holds unconsumed data
frame_ready  input  1  consumer accepts frame this cycle
busy  output  1  state is SCAN
ovf  output  1  sticky overrun flag; cleared only by rst

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: sel=0, frame=0, frame_valid=0, busy=0, ovf=0, state=IDLE, dwell counter=0, latched mask=0, shadow frame=0.
- Reset asserted mid-scan: the scan is abandoned; all reset values apply after that edge; no partial frame is emitted.
- States: IDLE and SCAN only.
- IDLE: on an edge where start=1 and mask!=0:
  - latch mask and clear the shadow frame;
  - sel <= lowest enabled channel; counter <= 0;
  - go to SCAN; busy=1 from the next cycle.
- IDLE with start=1 and mask=0: ignored; remain in IDLE.
- SCAN, counter != DWELL-1: counter increments; sel is held.
- SCAN, counter == DWELL-1:
  - shadow[sel] <= mux_out; counter <= 0;
  - if a higher enabled channel exists, sel <= next higher enabled channel;
  - otherwise this is frame completion (see below).
- Frame completion, all on the same edge:
  - the new frame is {shadow with the final bit just sampled}, disabled bits 0;
  - continuous=1: sel <= lowest enabled channel of the latched mask; stay in SCAN;
  - continuous=0: go to IDLE; busy=0 next cycle; sel holds its last value.
- Latency: start accepted at edge k with N enabled channels → frame and frame_valid update at edge k + N*DWELL. Each channel's sel is stable for exactly DWELL cycles.
- Handshake:
  - frame_valid && frame_ready at an edge → frame_valid <= 0, unless a new frame loads on the same edge, in which case frame updates and frame_valid stays 1;
  - frame is stable whenever frame_valid=1 and it has not yet been consumed.
- Overrun: a completion while frame_valid=1 && frame_ready=0:
  - the new frame is dropped; frame and frame_valid are unchanged;
  - ovf <= 1; scanning continues per continuous.
- Mid-scan input changes: start is ignored in SCAN; mask changes have no effect until the next accepted start.
- mux_out is assumed combinational from sel (one sel-stable cycle suffices); DWELL≥1 guarantees sel is stable on the sample cycle.
- DWELL=1: sel advances every cycle; a full-mask frame completes in 4 cycles.

Optional Feature:
MUX_SCAN_PARITY_EN
- Defined: adds output port frame_par (1 bit, reset 0). It is loaded on the same edge as frame, with the XOR of the 4 loaded frame bits (even parity), and is dropped together with the frame on overrun.
- Undefined: the frame_par port and its logic are absent; all other behaviour is identical.

Test Plan:
1. DWELL=4, mask=1111, mux_out=i[sel] with i=4'b1010, frame_ready=1, continuous=0, start pulse at edge k → sel=0,1,2,3 for 4 cycles each; frame=4'b1010, frame_valid=1 after edge k+16 for one cycle; busy low from k+17.
2. mask=4'b0101, i=4'b1111 → sel visits 0 then 2 only; frame=4'b0101 after edge k+8.
3. continuous=1, mask=4'b0001, i=4'b0001, frame_ready=0 → frame_valid at k+4, second completion at k+8 sets ovf=1 with frame unchanged; then raise frame_ready for one cycle → frame_valid clears, ovf stays 1.
4. start with mask=0 → busy stays 0 and sel stays 0; start pulse during SCAN → no restart, frame timing unchanged.
5. rst asserted at cycle k+6 of a scan → next cycle sel=0, busy=0, frame_valid=0, ovf=0; no frame is emitted.
6. With MUX_SCAN_PARITY_EN defined, i=4'b1011, mask=1111 → frame=4'b1011, frame_par=1; with i=4'b0011 → frame_par=0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Channel sequencer for a 4:1 single-bit mux: steps through the enabled channels and assembles one 4-bit frame per pass.
// Optional build macro MUX_SCAN_PARITY_EN adds the frame_par output (even parity of each frame that gets loaded).
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] mask,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
`ifdef MUX_SCAN_PARITY_EN
    output logic       frame_par,
`endif
    output logic       ovf
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         shadow_q, shadow_d;
    logic [3:0]         frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;
    logic               ovf_q, ovf_d;
`ifdef MUX_SCAN_PARITY_EN
    logic               frame_par_q, frame_par_d;
`endif

    logic               accept;
    logic               last_dwell;
    logic               complete;
    logic [2:0]         next_info;
    logic [3:0]         new_frame;

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        lowest_chan = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_chan = 2'(i);
        end
    endfunction

    // Returns {found, channel} for the lowest enabled channel strictly above cur.
    function automatic logic [2:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
        next_chan = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_chan = {1'b1, 2'(i)};
        end
    endfunction

    assign accept     = (state_q == IDLE) && start && (mask != 4'b0000);
    assign last_dwell = (cnt_q == CNT_W'(DWELL - 1));
    assign next_info  = next_chan(mask_q, sel_q);
    assign complete   = (state_q == SCAN) && last_dwell && !next_info[2];

    // The bit under sel is taken live from the mux on the completing edge; disabled channels read 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_frame_bit
            assign new_frame[gi] = mask_q[gi] & ((sel_q == 2'(gi)) ? mux_out : shadow_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sel_q         <= 2'd0;
            mask_q        <= 4'b0000;
            shadow_q      <= 4'b0000;
            frame_q       <= 4'b0000;
            frame_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: if (complete && !continuous) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        if (accept) begin
            mask_d   = mask;
            shadow_d = 4'b0000;
            sel_d    = lowest_chan(mask);
            cnt_d    = '0;
        end else if (state_q == SCAN) begin
            if (last_dwell) begin
                cnt_d           = '0;
                shadow_d[sel_q] = mux_out;
                if (next_info[2]) begin
                    sel_d = next_info[1:0];
                end else if (continuous) begin
                    sel_d    = lowest_chan(mask_q);
                    shadow_d = 4'b0000;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A completion against an unconsumed, unaccepted frame is dropped and flagged.
    always_comb begin
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        ovf_d         = ovf_q;
        if (complete) begin
            if (frame_valid_q && !frame_ready) begin
                ovf_d = 1'b1;
            end else begin
                frame_d       = new_frame;
                frame_valid_d = 1'b1;
            end
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) frame_par_q <= 1'b0;
        else     frame_par_q <= frame_par_d;
    end

    always_comb begin
        frame_par_d = frame_par_q;
        if (complete && !(frame_valid_q && !frame_ready)) frame_par_d = ^new_frame;
    end

    assign frame_par = frame_par_q;
`endif

    always_comb begin
        busy        = (state_q == SCAN);
        sel         = sel_q;
        frame       = frame_q;
        frame_valid = frame_valid_q;
        ovf         = ovf_q;
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: vector table of single-shot scans plus overrun, ignored-start and reset sequences.
module tb_mux_scan_ctrl;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst, start, continuous, mux_out, frame_ready;
    logic [3:0] mask, pattern, frame;
    logic [1:0] sel;
    logic       frame_valid, busy, ovf;
`ifdef MUX_SCAN_PARITY_EN
    logic       frame_par;
`endif

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic [3:0] m;
        logic [3:0] p;
        logic [3:0] ef;
        bit         mid_start;
    } vec_t;

    mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .mask(mask), .mux_out(mux_out), .sel(sel), .frame(frame),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
`ifdef MUX_SCAN_PARITY_EN
        .frame_par(frame_par),
`endif
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    assign mux_out = pattern[sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] nth_chan(input logic [3:0] m, input int n);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == n) return 2'(i);
                c++;
            end
        end
        return 2'd0;
    endfunction

    task automatic pop_and_check(input string tag);
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_queue: got empty scoreboard, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_frame"}, frame, e[3:0]);
`ifdef MUX_SCAN_PARITY_EN
            check({tag, "_par"}, frame_par, e[4]);
`endif
        end
    endtask

    task automatic run_scan(input vec_t v);
        int  n;
        bit  seen;
        n = $countones(v.m);
        exp_q.push_back({^v.ef, v.ef});
        mask = v.m; pattern = v.p; continuous = 1'b0; frame_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sel_first", sel, nth_chan(v.m, 0));
        check("busy_start", busy, 1);
        seen = 0;
        for (int t = 1; t <= 40 && !seen; t++) begin
            if (v.mid_start && t == 5) begin
                start = 1'b1;
                mask  = 4'b0001;
            end else begin
                start = 1'b0;
            end
            tick();
            if (frame_valid) begin
                seen = 1;
                check("latency", t, n * DWELL);
                $display("scan mask=%b pattern=%b frame=%b cycles=%0d", v.m, v.p, frame, t);
                pop_and_check("scan");
                tick();
                check("valid_drop", frame_valid, 0);
                check("busy_end", busy, 0);
            end else if (t < n * DWELL) begin
                check("sel_seq", sel, nth_chan(v.m, t / DWELL));
                check("busy_scan", busy, 1);
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL scan_timeout: got no frame_valid, expected one after %0d cycles", n * DWELL);
        end
    endtask

    initial begin
        vec_t vecs[8];
        bit   seen;
        int   lat;

        vecs[0] = '{m: 4'b1111, p: 4'b1010, ef: 4'b1010, mid_start: 0};
        vecs[1] = '{m: 4'b0101, p: 4'b1111, ef: 4'b0101, mid_start: 0};
        vecs[2] = '{m: 4'b1111, p: 4'b1011, ef: 4'b1011, mid_start: 0};
        vecs[3] = '{m: 4'b1111, p: 4'b0011, ef: 4'b0011, mid_start: 0};
        vecs[4] = '{m: 4'b1000, p: 4'b1111, ef: 4'b1000, mid_start: 0};
        vecs[5] = '{m: 4'b0110, p: 4'b1001, ef: 4'b0000, mid_start: 0};
        vecs[6] = '{m: 4'b1011, p: 4'b0110, ef: 4'b0010, mid_start: 0};
        vecs[7] = '{m: 4'b1111, p: 4'b1010, ef: 4'b1010, mid_start: 1};

        rst = 1'b1; start = 1'b0; continuous = 1'b0; mask = 4'b0000;
        pattern = 4'b0000; frame_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_sel", sel, 0);
        check("rst_frame", frame, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);

        // start with an empty mask must be ignored
        mask = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("empty_busy", busy, 0);
        check("empty_sel", sel, 0);
        $display("empty-mask start busy=%0d sel=%0d", busy, sel);

        for (int i = 0; i < 8; i++) run_scan(vecs[i]);

        // continuous scan into a stalled consumer
        mask = 4'b0001; pattern = 4'b0001; continuous = 1'b1; frame_ready = 1'b0;
        exp_q.push_back(5'b10001);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0; lat = 0;
        for (int t = 1; t <= 20 && !seen; t++) begin
            tick();
            if (frame_valid) begin seen = 1; lat = t; end
        end
        check("ovr_first_latency", lat, 4);
        check("ovr_first_frame", frame, exp_q[0][3:0]);
        check("ovr_first_ovf", ovf, 0);
        pattern = 4'b0000;
        tick(); tick(); tick();
        check("ovr_pre_ovf", ovf, 0);
        tick();
        check("ovr_ovf", ovf, 1);
        check("ovr_valid_held", frame_valid, 1);
        check("ovr_frame_held", frame, exp_q[0][3:0]);
        $display("overrun frame=%b ovf=%0d", frame, ovf);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        pop_and_check("ovr_consume");
        check("ovr_valid_clear", frame_valid, 0);
        check("ovr_sticky", ovf, 1);
        continuous = 1'b0;
        exp_q.push_back(5'b00000);
        seen = 0; lat = 0;
        for (int t = 1; t <= 10 && !seen; t++) begin
            tick();
            if (frame_valid) begin seen = 1; lat = t; end
        end
        check("ovr_last_latency", lat, 3);
        pop_and_check("ovr_last");
        tick();
        check("ovr_last_busy", busy, 0);
        check("ovr_last_valid", frame_valid, 1);
        frame_ready = 1'b1;
        tick();
        check("ovr_last_drop", frame_valid, 0);
        $display("continuous stop frame=%b ovf=%0d", frame, ovf);

        // reset in the middle of a scan
        mask = 4'b1111; pattern = 4'b1111; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        check("midrst_sel_before", sel, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sel", sel, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", frame_valid, 0);
        check("midrst_ovf", ovf, 0);
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (frame_valid) seen = 1;
        end
        check("midrst_no_frame", seen, 0);
        $display("mid-scan reset sel=%0d busy=%0d ovf=%0d", sel, busy, ovf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
